hex_word_entry: RTL and testbench

Operator-input block for the FPGA board: builds a 32-bit hex word one nibble at a time from 4 slide switches and three active-low push keys, then hands the word to the CPU over a valid/ready handshake. o_word feeds the seven-segment hex decoder so the operator sees the value being typed. Sits between board I/O pins and the CPU debug/MMIO input port.

---
 rtl/hex_word_entry.sv | 123 ++++++++++++
 tb/tb_hex_word_entry.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_word_entry.sv
// Operator hex-word entry: debounced push/clear/commit keys build a 32-bit word
// nibble by nibble, then hand it to the CPU over a valid/ready handshake.
module hex_word_entry #(
  parameter int DEB_CYCLES = 50000,
  parameter int CNT_W      = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_sw,
  input  logic        i_key_push_n,
  input  logic        i_key_clear_n,
  input  logic        i_key_commit_n,
  output logic [31:0] o_word,
  output logic [3:0]  o_digits,
  output logic [31:0] o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_busy
);

  // Handshake: o_data is offered while o_valid is high and is held stable;
  // the transfer happens on the rising edge that samples o_valid && i_ready.

  typedef enum logic {ENTRY = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  state_t     state, state_n;
  logic [2:0] raw_n;
  logic [2:0] press;
  logic       ev_push, ev_clear, ev_commit;

  assign raw_n = {i_key_commit_n, i_key_clear_n, i_key_push_n};

  // Per key: 2-flop synchronizer, stable-count debounce, one-cycle press pulse.
  for (genvar g = 0; g < 3; g++) begin : g_key
    logic             s1, s2, deb, deb_d, ev;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        s1    <= 1'b1;
        s2    <= 1'b1;
        deb   <= 1'b1;
        deb_d <= 1'b1;
        ev    <= 1'b0;
        cnt   <= '0;
      end else begin
        s1    <= raw_n[g];
        s2    <= s1;
        deb_d <= deb;
        ev    <= deb_d & ~deb;
        if (s2 == deb) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          deb <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press[g] = ev;
  end

  assign ev_push   = press[0];
  assign ev_clear  = press[1];
  assign ev_commit = press[2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ENTRY;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ENTRY: if (!ev_clear && ev_commit) state_n = HOLD;
      HOLD:  if (o_valid && i_ready)     state_n = ENTRY;
    endcase
  end

  always_comb begin
    o_busy = (state == HOLD);
  end

  // Clear outranks commit, which outranks push; keys are ignored in HOLD.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_word   <= '0;
      o_digits <= '0;
      o_data   <= '0;
      o_valid  <= 1'b0;
    end else begin
      case (state)
        ENTRY: begin
          if (ev_clear) begin
            o_word   <= '0;
            o_digits <= '0;
          end else if (ev_commit) begin
            o_data  <= o_word;
            o_valid <= 1'b1;
          end else if (ev_push) begin
            o_word <= {o_word[27:0], i_sw};
            if (o_digits != 4'd8) o_digits <= o_digits + 4'd1;
          end
        end
        HOLD: begin
          if (o_valid && i_ready) begin
            o_valid  <= 1'b0;
            o_word   <= '0;
            o_digits <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_word_entry.sv
// Bench for hex_word_entry: directed scenarios plus random key activity, all
// outputs compared every cycle against a behavioural model of the key path.
module tb_hex_word_entry;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_sw;
  logic        push_n, clear_n, commit_n;
  logic [31:0] o_word, o_data;
  logic [3:0]  o_digits;
  logic        o_valid, o_busy, i_ready;

  int n_checks = 0;
  int n_fail   = 0;

  hex_word_entry #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sw           (i_sw),
    .i_key_push_n   (push_n),
    .i_key_clear_n  (clear_n),
    .i_key_commit_n (commit_n),
    .o_word         (o_word),
    .o_digits       (o_digits),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_busy         (o_busy)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // hist[k][j] is the pin level sampled j edges ago; a key's debounced level
  // flips once the synchronized pin has shown the other level DEB edges in a row.
  logic [DEB+1:0] hist [3];
  logic [2:0]     m_deb, p1, p2, act, fell;
  logic [31:0]    m_word, m_data;
  logic [3:0]     m_digits;
  logic           m_valid, m_hold;
  logic [2:0]     pins;

  assign pins = {commit_n, clear_n, push_n};

  task automatic m_reset();
    for (int k = 0; k < 3; k++) hist[k] = '1;
    m_deb = 3'b111; p1 = '0; p2 = '0;
    m_word = '0; m_data = '0; m_digits = '0; m_valid = 1'b0; m_hold = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else begin
      act = p2;
      if (m_hold) begin
        if (i_ready) begin
          m_hold = 1'b0; m_valid = 1'b0; m_word = '0; m_digits = '0;
        end
      end else if (act[1]) begin
        m_word = '0; m_digits = '0;
      end else if (act[2]) begin
        m_data = m_word; m_valid = 1'b1; m_hold = 1'b1;
      end else if (act[0]) begin
        m_word = (m_word << 4) | {28'd0, i_sw};
        m_digits = (m_digits < 8) ? m_digits + 4'd1 : 4'd8;
      end
      p2 = p1;
      fell = '0;
      for (int k = 0; k < 3; k++) begin
        hist[k] = {hist[k][DEB:0], pins[k]};
        if (m_deb[k] && hist[k][DEB+1:2] == {DEB{1'b0}}) begin
          m_deb[k] = 1'b0; fell[k] = 1'b1;
        end else if (!m_deb[k] && hist[k][DEB+1:2] == {DEB{1'b1}}) begin
          m_deb[k] = 1'b1;
        end
      end
      p1 = fell;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    check("word",   o_word,          m_word);
    check("digits", {28'd0, o_digits}, {28'd0, m_digits});
    check("data",   o_data,          m_data);
    check("valid",  {31'd0, o_valid}, {31'd0, m_valid});
    check("busy",   {31'd0, o_busy},  {31'd0, m_hold});
  end

  // ---------------- driver tasks ----------------
  task automatic set_pin(input int key, input logic v);
    case (key)
      0: push_n   = v;
      1: clear_n  = v;
      default: commit_n = v;
    endcase
  endtask

  task automatic press(input int key, input logic [3:0] sw, input int hold);
    @(negedge clk);
    i_sw = sw;
    set_pin(key, 1'b0);
    repeat (hold) @(negedge clk);
    set_pin(key, 1'b1);
    repeat (DEB + 6) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; i_sw = '0; push_n = 1'b1; clear_n = 1'b1; commit_n = 1'b1; i_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_word",  o_word, 32'h0);
    check("reset_valid", {31'd0, o_valid}, 32'h0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_word",   o_word, 32'h0);
    check("idle_digits", {28'd0, o_digits}, 32'h0);

    // first push: exact latency from first sampling edge
    @(negedge clk);
    i_sw = 4'h1; push_n = 1'b0;
    repeat (DEB + 3) @(posedge clk);
    #1 check("latency_early", {28'd0, o_digits}, 32'd0);
    @(posedge clk);
    #1 check("latency_at", {28'd0, o_digits}, 32'd1);
    check("latency_word", o_word, 32'h1);
    @(negedge clk); push_n = 1'b1;
    repeat (DEB + 6) @(negedge clk);

    for (int i = 2; i <= 8; i++) press(0, 4'(i), DEB + 2);
    check("eight_word",   o_word, 32'h12345678);
    check("eight_digits", {28'd0, o_digits}, 32'd8);
    press(0, 4'h9, DEB + 2);
    check("ninth_word",   o_word, 32'h23456789);
    check("ninth_digits", {28'd0, o_digits}, 32'd8);

    // glitch, long hold, re-press
    press(0, 4'hA, 3);
    check("glitch_word", o_word, 32'h23456789);
    press(0, 4'hB, 50);
    check("hold_word", o_word, 32'h3456789B);
    press(0, 4'hC, DEB + 2);
    check("repress_word", o_word, 32'h456789BC);

    // commit with CPU stalled, push ignored in HOLD
    press(1, 4'h0, DEB + 2);
    for (int i = 1; i <= 8; i++) press(0, 4'(i), DEB + 2);
    press(2, 4'h0, DEB + 2);
    repeat (5) @(negedge clk);
    check("hold_valid", {31'd0, o_valid}, 32'd1);
    check("hold_data",  o_data, 32'h12345678);
    check("hold_busy",  {31'd0, o_busy}, 32'd1);
    press(0, 4'hF, DEB + 2);
    check("hold_push_ignored", o_word, 32'h12345678);
    i_ready = 1'b1;
    @(posedge clk);
    #1 check("xfer_valid",  {31'd0, o_valid}, 32'd0);
    check("xfer_word",   o_word, 32'h0);
    check("xfer_digits", {28'd0, o_digits}, 32'd0);
    check("xfer_busy",   {31'd0, o_busy}, 32'd0);
    @(negedge clk); i_ready = 1'b0;

    // clear and push together: clear wins
    press(0, 4'hA, DEB + 2);
    press(0, 4'hB, DEB + 2);
    press(0, 4'hC, DEB + 2);
    check("abc_word", o_word, 32'hABC);
    @(negedge clk);
    i_sw = 4'hD; push_n = 1'b0; clear_n = 1'b0;
    repeat (DEB + 2) @(negedge clk);
    push_n = 1'b1; clear_n = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    check("coincide_word",   o_word, 32'h0);
    check("coincide_digits", {28'd0, o_digits}, 32'd0);

    // asynchronous reset during HOLD
    press(0, 4'h5, DEB + 2);
    press(2, 4'h0, DEB + 2);
    check("pre_reset_busy", {31'd0, o_busy}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_valid", {31'd0, o_valid}, 32'd0);
    check("async_busy", {31'd0, o_busy}, 32'd0);
    check("async_word", o_word, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_busy", {31'd0, o_busy}, 32'd0);

    // random key activity checked cycle by cycle against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      i_sw    = 4'($urandom_range(0, 15));
      i_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) push_n   = ~push_n;
      if ($urandom_range(0, 40) == 0) clear_n = ~clear_n;
      else if (!clear_n && $urandom_range(0, 3) == 0) clear_n = 1'b1;
      if ($urandom_range(0, 12) == 0) commit_n = ~commit_n;
    end
    push_n = 1'b1; clear_n = 1'b1; commit_n = 1'b1; i_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
